// File: rtl/bird_motion.sv
// Per-frame bird kinematics: Q12.4 position/velocity integration, tilt ramp, wing animation
// and the idle/play/fall/grounded life cycle. All state advances on frame_tick.
module bird_motion #(
  parameter int BIRD_X      = 60,
  parameter int START_Y     = 200,
  parameter int GROUND_Y    = 400,
  parameter int GRAVITY     = 6,
  parameter int FLAP_VEL    = 112,
  parameter int MAX_FALL    = 160,
  parameter int ANG_UP      = 16,
  parameter int ANG_STEP    = 4,
  parameter int HOLD_FRAMES = 12,
  parameter int ANIM_DIV    = 5,
  parameter int BOB_AMP     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               flap,
  input  logic               collide,
  input  logic               restart,
  output logic signed [15:0] pos_x,
  output logic signed [15:0] pos_y,
  output logic signed [7:0]  angle,
  output logic [1:0]         bird_status,
  output logic               dead,
  output logic               grounded
);

  typedef enum logic [1:0] {StIdle, StPlay, StFall, StGround} state_e;

  localparam logic signed [15:0] StartPos   = 16'(START_Y * 16);
  localparam logic signed [15:0] GroundPos  = 16'(GROUND_Y * 16);
  localparam logic signed [15:0] Grav       = 16'(GRAVITY);
  localparam logic signed [15:0] FlapVel    = 16'(FLAP_VEL);
  localparam logic signed [15:0] MaxFall    = 16'(MAX_FALL);
  localparam logic signed [15:0] BobSpan    = 16'(BOB_AMP * 16);
  localparam logic signed [15:0] OnePx      = 16'sd16;
  localparam logic signed [7:0]  AngUp      = 8'(ANG_UP);
  localparam logic signed [7:0]  AngStep    = 8'(ANG_STEP);
  localparam logic signed [7:0]  AngStep2   = 8'(2 * ANG_STEP);
  localparam logic signed [7:0]  AngMax     = 8'sd63;
  localparam logic [7:0]         HoldFrames = 8'(HOLD_FRAMES);
  localparam logic [7:0]         AnimLast   = 8'(ANIM_DIV - 1);

  state_e             state_q, state_d;
  logic signed [15:0] pos_q, pos_d;
  logic signed [15:0] vel_q, vel_d;
  logic signed [7:0]  angle_q, angle_d;
  logic [7:0]         hold_q, hold_d;
  logic [7:0]         anim_cnt_q, anim_cnt_d;
  logic [1:0]         status_q, status_d;
  logic               anim_up_q, anim_up_d;
  logic               bob_down_q, bob_down_d;
  logic               flap_pend_q, flap_pend_d;
  logic               coll_pend_q, coll_pend_d;

  logic               flap_eff, coll_eff, do_flap, soft_rst;
  logic signed [15:0] vel_sum, vel_grav, vel_new, pos_sum, mot_pos, mot_vel;
  logic               hit_ceil, hit_ground;
  logic signed [15:0] pos_bob, bob_off;
  logic               bob_edge;
  logic signed [7:0]  ang_sum, ang_play, ang_sum2, ang_fall;
  logic [7:0]         anim_cnt_nxt;
  logic [1:0]         status_nxt;
  logic               anim_up_nxt;

  // A pulse arriving in the same cycle as the tick counts for that tick.
  assign flap_eff = flap_pend_q | flap;
  assign coll_eff = coll_pend_q | collide;
  assign do_flap  = (state_q == StIdle) | ((state_q == StPlay) & flap_eff & ~coll_eff);
  assign soft_rst = (state_q == StGround) & restart;

  always_comb begin
    vel_sum    = vel_q + Grav;
    vel_grav   = (vel_sum > MaxFall) ? MaxFall : vel_sum;
    vel_new    = do_flap ? -FlapVel : vel_grav;
    pos_sum    = pos_q + vel_new;
    hit_ceil   = pos_sum < 16'sd0;
    hit_ground = pos_sum >= GroundPos;
    mot_pos    = hit_ceil ? 16'sd0 : (hit_ground ? GroundPos : pos_sum);
    mot_vel    = (hit_ceil | hit_ground) ? 16'sd0 : vel_new;

    ang_sum    = angle_q + AngStep;
    ang_play   = (ang_sum > AngMax) ? AngMax : ang_sum;
    ang_sum2   = angle_q + AngStep2;
    ang_fall   = (ang_sum2 > AngMax) ? AngMax : ang_sum2;

    pos_bob    = bob_down_q ? (pos_q + OnePx) : (pos_q - OnePx);
    bob_off    = pos_bob - StartPos;
    bob_edge   = (bob_off == BobSpan) || (bob_off == -BobSpan);
  end

  // Wing frame ping-pongs 0,1,2,1,0,... once per ANIM_DIV ticks.
  always_comb begin
    anim_cnt_nxt = anim_cnt_q + 8'd1;
    status_nxt   = status_q;
    anim_up_nxt  = anim_up_q;
    if (anim_cnt_q == AnimLast) begin
      anim_cnt_nxt = 8'd0;
      if (anim_up_q) begin
        status_nxt  = status_q + 2'd1;
        anim_up_nxt = (status_q != 2'd1);
      end else begin
        status_nxt  = status_q - 2'd1;
        anim_up_nxt = (status_q == 2'd1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    vel_d       = vel_q;
    angle_d     = angle_q;
    hold_d      = hold_q;
    anim_cnt_d  = anim_cnt_q;
    status_d    = status_q;
    anim_up_d   = anim_up_q;
    bob_down_d  = bob_down_q;
    flap_pend_d = flap_eff;
    coll_pend_d = coll_eff;
    if (frame_tick) flap_pend_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (frame_tick) begin
          coll_pend_d = 1'b0;
          anim_cnt_d  = anim_cnt_nxt;
          status_d    = status_nxt;
          anim_up_d   = anim_up_nxt;
          if (flap_eff) begin
            state_d = StPlay;
            pos_d   = mot_pos;
            vel_d   = mot_vel;
            angle_d = -AngUp;
            hold_d  = HoldFrames;
          end else begin
            pos_d   = pos_bob;
            vel_d   = 16'sd0;
            angle_d = 8'sd0;
            if (bob_edge) bob_down_d = ~bob_down_q;
          end
        end
      end
      StPlay: begin
        if (frame_tick) begin
          anim_cnt_d = anim_cnt_nxt;
          status_d   = status_nxt;
          anim_up_d  = anim_up_nxt;
          pos_d      = mot_pos;
          vel_d      = mot_vel;
          if (do_flap) begin
            angle_d = -AngUp;
            hold_d  = HoldFrames;
          end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end else begin
            angle_d = ang_play;
          end
          if (hit_ground) begin
            state_d = StGround;
          end else if (coll_eff) begin
            state_d     = StFall;
            coll_pend_d = 1'b0;
          end
        end
      end
      StFall: begin
        if (frame_tick) begin
          pos_d   = mot_pos;
          vel_d   = mot_vel;
          angle_d = ang_fall;
          if (hit_ground) state_d = StGround;
        end
      end
      StGround: begin
        pos_d = GroundPos;
        vel_d = 16'sd0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Restart from the ground reloads exactly the reset image.
  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      state_q     <= StIdle;
      pos_q       <= StartPos;
      vel_q       <= 16'sd0;
      angle_q     <= 8'sd0;
      hold_q      <= 8'd0;
      anim_cnt_q  <= 8'd0;
      status_q    <= 2'd0;
      anim_up_q   <= 1'b1;
      bob_down_q  <= 1'b1;
      flap_pend_q <= 1'b0;
      coll_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      vel_q       <= vel_d;
      angle_q     <= angle_d;
      hold_q      <= hold_d;
      anim_cnt_q  <= anim_cnt_d;
      status_q    <= status_d;
      anim_up_q   <= anim_up_d;
      bob_down_q  <= bob_down_d;
      flap_pend_q <= flap_pend_d;
      coll_pend_q <= coll_pend_d;
    end
  end

  assign pos_x       = 16'(BIRD_X);
  assign pos_y       = pos_q >>> 4;
  assign angle       = angle_q;
  assign bird_status = status_q;
  assign dead        = (state_q == StFall) || (state_q == StGround);
  assign grounded    = (state_q == StGround);

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: bob, flap/hold/tilt ramp, terminal velocity, collision fall,
// ceiling clamp, restart and mid-fall reset, with hand-derived expected values.
module tb_bird_motion;

  logic               clk = 1'b0;
  logic               rst, frame_tick, flap, collide, restart;
  logic signed [15:0] pos_x, pos_y;
  logic signed [7:0]  angle;
  logic [1:0]         bird_status;
  logic               dead, grounded;

  int n_checks = 0;
  int n_errors = 0;
  int pos_m, vel_m;
  int bob_exp[8] = '{201, 202, 203, 204, 203, 202, 201, 200};

  always #5 clk = ~clk;

  bird_motion dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .flap        (flap),
    .collide     (collide),
    .restart     (restart),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .angle       (angle),
    .bird_status (bird_status),
    .dead        (dead),
    .grounded    (grounded)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge after the update.
  task automatic do_tick(input logic with_flap);
    @(negedge clk);
    frame_tick = 1'b1;
    flap       = with_flap;
    @(negedge clk);
    frame_tick = 1'b0;
    flap       = 1'b0;
  endtask

  task automatic pulse(input int sel);
    @(negedge clk);
    case (sel)
      0: flap = 1'b1;
      1: collide = 1'b1;
      default: restart = 1'b1;
    endcase
    @(negedge clk);
    flap    = 1'b0;
    collide = 1'b0;
    restart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic model_step(input bit fl);
    if (fl) vel_m = -112;
    else vel_m = (vel_m + 6 > 160) ? 160 : vel_m + 6;
    pos_m = pos_m + vel_m;
    if (pos_m < 0) begin
      pos_m = 0;
      vel_m = 0;
    end else if (pos_m >= 6400) begin
      pos_m = 6400;
      vel_m = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pos_x"}, pos_x, 60);
    check_val({tag, "_pos_y"}, pos_y, 200);
    check_val({tag, "_angle"}, angle, 0);
    check_val({tag, "_status"}, bird_status, 0);
    check_val({tag, "_dead"}, dead, 0);
    check_val({tag, "_grounded"}, grounded, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; flap = 1'b0; collide = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Idle bob
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b0);
      check_val($sformatf("bob_%0d", i), pos_y, bob_exp[i]);
    end
    check_val("bob_angle", angle, 0);
    check_val("bob_dead", dead, 0);
    check_val("bob_status", bird_status, 1);

    // Flap from idle, then free flight to the ground
    do_reset();
    do_tick(1'b1);
    check_val("flap_pos", pos_y, 193);
    check_val("flap_angle", angle, -16);
    pos_m = 3088;
    vel_m = -112;
    for (int n = 2; n <= 59; n++) begin
      if (n == 20) begin
        pulse(2);
        check_val("play_restart_pos", pos_y, pos_m / 16);
        check_val("play_restart_dead", dead, 0);
      end
      do_tick(1'b0);
      model_step(1'b0);
      check_val($sformatf("play_pos_%0d", n), pos_y, pos_m / 16);
      if (n == 2)  check_val("play_pos_hand", pos_y, 186);
      if (n == 10) check_val("anim_10", bird_status, 2);
      if (n == 13) check_val("hold_end", angle, -16);
      if (n == 14) check_val("ramp_1", angle, -12);
      if (n == 15) check_val("ramp_2", angle, -8);
      if (n == 32) check_val("ramp_19", angle, 60);
      if (n == 33) check_val("ramp_clamp", angle, 63);
      if (n == 34) check_val("ramp_held", angle, 63);
      if (n == 57) check_val("anim_57", bird_status, 1);
      if (n >= 47) check_val($sformatf("term_vel_%0d", n), pos_y, (4418 + 160 * (n - 47)) / 16);
      check_val($sformatf("play_grounded_%0d", n), grounded, 0);
    end
    do_tick(1'b0);
    check_val("ground_flag", grounded, 1);
    check_val("ground_dead", dead, 1);
    check_val("ground_pos", pos_y, 400);
    check_val("ground_angle", angle, 63);
    do_tick(1'b1);
    check_val("ground_stay", pos_y, 400);

    // Restart from the ground
    pulse(2);
    check_reset_outputs("restart");
    do_tick(1'b0);
    check_val("restart_bob", pos_y, 201);

    // Collision then fall; flaps during the fall are ignored
    do_reset();
    do_tick(1'b1);
    do_tick(1'b0);
    check_val("pre_coll_pos", pos_y, 186);
    pulse(1);
    pulse(0);
    do_tick(1'b0);
    check_val("coll_dead", dead, 1);
    check_val("coll_pos", pos_y, 180);
    check_val("coll_angle", angle, -16);
    pos_m = 2882;
    vel_m = -100;
    for (int k = 1; k <= 100; k++) begin
      do_tick(k[0]);
      model_step(1'b0);
      check_val($sformatf("fall_pos_%0d", k), pos_y, pos_m / 16);
      check_val($sformatf("fall_grounded_%0d", k), grounded, (pos_m == 6400) ? 1 : 0);
      if (k == 1)  check_val("fall_ang_1", angle, -8);
      if (k == 2)  check_val("fall_ang_2", angle, 0);
      if (k == 10) check_val("fall_ang_10", angle, 63);
      if (k == 11) check_val("fall_ang_11", angle, 63);
      if (pos_m == 6400) break;
      if (k == 100) check_val("fall_budget", 0, 1);
    end

    // Reset asserted mid-fall, together with a tick and a flap
    do_reset();
    pulse(0);
    do_tick(1'b0);
    check_val("pend_flap_pos", pos_y, 193);
    pulse(1);
    do_tick(1'b0);
    check_val("fall2_dead", dead, 1);
    do_tick(1'b0);
    @(negedge clk);
    rst        = 1'b1;
    frame_tick = 1'b1;
    flap       = 1'b1;
    @(negedge clk);
    check_reset_outputs("midfall_rst");
    rst        = 1'b0;
    frame_tick = 1'b0;
    flap       = 1'b0;

    // Ceiling clamp under repeated flaps
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      do_tick(1'b1);
      check_val($sformatf("ceil_%0d", n), pos_y, ((3200 - 112 * n) > 0) ? (3200 - 112 * n) / 16 : 0);
      if (n == 15) check_val("anim_15", bird_status, 1);
      if (n == 20) check_val("anim_20", bird_status, 0);
    end
    do_tick(1'b0);
    check_val("ceil_vel0_a", pos_y, 0);
    do_tick(1'b0);
    check_val("ceil_vel0_b", pos_y, 1);
    check_val("ceil_dead", dead, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
